// File: rtl/game_ctrl_if.sv
// game_ctrl_if: button/miss inputs and scoreboard outputs of the game controller.
interface game_ctrl_if;
    logic       start_key;
    logic       serve_key;
    logic       miss_left;
    logic       miss_right;
    logic [1:0] state;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       server;
    logic       winner;
    logic       point;
    modport master (
        output start_key, serve_key, miss_left, miss_right,
        input  state, score_l, score_r, server, winner, point
    );
    modport slave (
        input  start_key, serve_key, miss_left, miss_right,
        output state, score_l, score_r, server, winner, point
    );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: pong match sequencer (start/serve/play/done, scoring, winner).
// Optional AUTO_SERVE_EN: leave SERVE after SERVE_DELAY cycles instead of on serve_key.
module game_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 500000
) (
    input logic        clk,
    input logic        rst,
    game_ctrl_if.slave g
);
    typedef enum logic [1:0] {START = 2'b00, SERVE = 2'b01, PLAY = 2'b10, DONE = 2'b11} state_t;
    localparam logic [3:0] WIN = 4'(WIN_SCORE);
    state_t     st, st_n;
    logic [3:0] sl, sl_n, sr, sr_n;
    logic       srv, srv_n, win, win_n, pt, pt_n;
    logic       start_q, start_edge, go;
    logic [3:0] sl_inc, sr_inc;
    assign start_edge = g.start_key & ~start_q;
    assign sl_inc     = sl + 4'd1;
    assign sr_inc     = sr + 4'd1;
`ifdef AUTO_SERVE_EN
    localparam logic [19:0] LAST = 20'(SERVE_DELAY - 1);
    logic [19:0] cnt;
    assign go = (cnt == LAST);
    always_ff @(posedge clk)
        cnt <= (rst || st != SERVE) ? 20'd0 : cnt + 20'd1;
`else
    logic serve_q;
    assign go = g.serve_key & ~serve_q;
    always_ff @(posedge clk)
        serve_q <= rst ? 1'b1 : g.serve_key;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= START;
            sl      <= 4'd0;
            sr      <= 4'd0;
            srv     <= 1'b0;
            win     <= 1'b0;
            pt      <= 1'b0;
            start_q <= 1'b1;
        end else begin
            st      <= st_n;
            sl      <= sl_n;
            sr      <= sr_n;
            srv     <= srv_n;
            win     <= win_n;
            pt      <= pt_n;
            start_q <= g.start_key;
        end
    end
    always_comb begin
        st_n  = st;
        sl_n  = sl;
        sr_n  = sr;
        srv_n = srv;
        win_n = win;
        pt_n  = 1'b0;
        case (st)
            START: st_n = start_edge ? SERVE : START;
            SERVE: st_n = go ? PLAY : SERVE;
            PLAY: begin
                if (g.miss_left && g.miss_right) begin
                    st_n = SERVE;
                end else if (g.miss_left) begin
                    sr_n  = (sr < WIN) ? sr_inc : sr;
                    srv_n = 1'b0;
                    pt_n  = 1'b1;
                    st_n  = (sr_inc == WIN) ? DONE : SERVE;
                    win_n = (sr_inc == WIN) ? 1'b1 : win;
                end else if (g.miss_right) begin
                    sl_n  = (sl < WIN) ? sl_inc : sl;
                    srv_n = 1'b1;
                    pt_n  = 1'b1;
                    st_n  = (sl_inc == WIN) ? DONE : SERVE;
                    win_n = (sl_inc == WIN) ? 1'b0 : win;
                end
            end
            DONE: begin
                // scores clear on the same edge that returns to START
                if (start_edge) begin
                    st_n  = START;
                    sl_n  = 4'd0;
                    sr_n  = 4'd0;
                    srv_n = 1'b0;
                end
            end
            default: st_n = START;
        endcase
    end
    assign g.state   = st;
    assign g.score_l = sl;
    assign g.score_r = sr;
    assign g.server  = srv;
    assign g.winner  = win;
    assign g.point   = pt;
endmodule
